// File: rtl/lcd_char_ctrl.sv
// HD44780 character LCD controller: power-up init, single-byte writes, cursor tracking, automatic line wrap.
// Optional LCD_BUSY_POLL_EN: post-init waits become busy-flag polling with a CLR_CYC timeout.
module lcd_char_ctrl #(
  parameter int   COLS      = 16,
  parameter int   ROWS      = 2,
  parameter int   PWRUP_CYC = 750000,
  parameter int   EN_CYC    = 16,
  parameter int   CMD_CYC   = 2000,
  parameter int   CLR_CYC   = 82000,
  parameter logic BLON      = 1'b0
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       LCD_ON,
  output logic       LCD_BLON,
  output logic       LCD_EN,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_DATA
);

  localparam int MAXC = (PWRUP_CYC > CLR_CYC) ? PWRUP_CYC : CLR_CYC;
  localparam int CW   = $clog2(MAXC + 2);

  typedef enum logic [3:0] {
    PWR_WAIT, INIT_SETUP, SETUP, EN_HI, WAIT, IDLE, WRAP, POLL_HOLD, POLL_SETUP, POLL_EN
  } state_t;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: init_byte = 8'h30;
      3'd3:             init_byte = 8'h38;
      3'd4:             init_byte = 8'h0C;
      3'd5:             init_byte = 8'h01;
      3'd6:             init_byte = 8'h06;
      default:          init_byte = 8'h80;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = 8'h14;
      default: row_base = 8'h54;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            long_q, long_d;
  logic            wrap_q, wrap_d;
  logic [1:0]      row_q, row_d;
  logic [5:0]      col_q, col_d;
  logic            en_q, en_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            wait_over;
  logic [1:0]      dec_row, next_row;
  logic [5:0]      dec_col;
  logic [7:0]      addr;
  logic [CW-1:0]   wait_lim;

`ifdef LCD_BUSY_POLL_EN
  localparam int TW = $clog2(CLR_CYC + EN_CYC + 4);
  logic          rw_q, rw_d;
  logic [TW-1:0] to_q, to_d;
  assign LCD_RW   = rw_q;
  assign LCD_DATA = rw_q ? 8'hzz : data_q;
`else
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;
`endif

  assign in_ready  = ready_q;
  assign init_done = done_q;
  assign LCD_EN    = en_q;
  assign LCD_RS    = rs_q;
  assign LCD_ON    = 1'b1;
  assign LCD_BLON  = BLON;

  assign addr     = {1'b0, in_data[6:0]};
  assign next_row = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
  assign wait_lim = long_q ? CW'(CLR_CYC - 1) : CW'(CMD_CYC - 1);

  // Lowest matching row wins when row ranges overlap.
  always_comb begin
    dec_row = 2'd0;
    dec_col = 6'd0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (addr >= row_base(2'(r)) && addr < row_base(2'(r)) + 8'(COLS)) begin
        dec_row = 2'(r);
        dec_col = 6'(addr - row_base(2'(r)));
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    long_d    = long_q;
    wrap_d    = wrap_q;
    row_d     = row_q;
    col_d     = col_q;
    en_d      = en_q;
    rs_d      = rs_q;
    data_d    = data_q;
    ready_d   = ready_q;
    done_d    = done_q;
    wait_over = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    rw_d      = rw_q;
    to_d      = to_q;
`endif
    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == CW'(PWRUP_CYC)) begin
          state_d = INIT_SETUP;
          cnt_d   = '0;
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          data_d  = init_byte(3'd0);
          long_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INIT_SETUP, SETUP, WRAP: begin
        state_d = EN_HI;
        en_d    = 1'b1;
        cnt_d   = '0;
      end
      EN_HI: begin
        if (cnt_q == CW'(EN_CYC - 1)) begin
          en_d  = 1'b0;
          cnt_d = '0;
`ifdef LCD_BUSY_POLL_EN
          state_d = done_q ? POLL_HOLD : WAIT;
`else
          state_d = WAIT;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (cnt_q == wait_lim) begin
          cnt_d     = '0;
          wait_over = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      IDLE: begin
        if (in_valid) begin
          state_d = SETUP;
          ready_d = 1'b0;
          rs_d    = in_rs;
          data_d  = in_data;
          long_d  = 1'b0;
          if (in_rs) begin
            col_d  = col_q + 6'd1;
            wrap_d = (col_q + 6'd1 == 6'(COLS));
          end else if (in_data == 8'h01 || in_data == 8'h02) begin
            long_d = 1'b1;
            row_d  = 2'd0;
            col_d  = 6'd0;
          end else if (in_data[7]) begin
            row_d = dec_row;
            col_d = dec_col;
          end
        end
      end
`ifdef LCD_BUSY_POLL_EN
      // Data stays driven one clock after the EN fall before the bus turns around.
      POLL_HOLD: begin
        state_d = POLL_SETUP;
        rw_d    = 1'b1;
        rs_d    = 1'b0;
        to_d    = '0;
      end
      POLL_SETUP: begin
        state_d = POLL_EN;
        en_d    = 1'b1;
        cnt_d   = '0;
        to_d    = to_q + TW'(1);
      end
      POLL_EN: begin
        to_d = to_q + TW'(1);
        if (cnt_q == CW'(EN_CYC - 1)) begin
          en_d  = 1'b0;
          cnt_d = '0;
          if (LCD_DATA[7] && (to_q + TW'(1)) < TW'(CLR_CYC)) begin
            state_d = POLL_SETUP;
          end else begin
            rw_d      = 1'b0;
            wait_over = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
`endif
      default: state_d = PWR_WAIT;
    endcase

    if (wait_over) begin
      if (!done_q) begin
        if (idx_q == 3'd7) begin
          state_d = IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = INIT_SETUP;
          rs_d    = 1'b0;
          data_d  = init_byte(idx_q + 3'd1);
          long_d  = (init_byte(idx_q + 3'd1) == 8'h01);
        end
      end else if (wrap_q) begin
        state_d = WRAP;
        wrap_d  = 1'b0;
        rs_d    = 1'b0;
        data_d  = 8'h80 | row_base(next_row);
        row_d   = next_row;
        col_d   = 6'd0;
        long_d  = 1'b0;
      end else begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= PWR_WAIT;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      long_q  <= 1'b0;
      wrap_q  <= 1'b0;
      row_q   <= 2'd0;
      col_q   <= 6'd0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      rw_q    <= 1'b0;
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      long_q  <= long_d;
      wrap_q  <= wrap_d;
      row_q   <= row_d;
      col_q   <= col_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      done_q  <= done_d;
`ifdef LCD_BUSY_POLL_EN
      rw_q    <= rw_d;
      to_q    <= to_d;
`endif
    end
  end

endmodule
